// File: rtl/iob_clint_pkg.sv
// iob_clint_pkg: register map constants and byte-strobe merge shared by the CLINT files
package iob_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;
    localparam logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace only the bytes of a 32-bit word whose strobe is set
    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/iob_clint_timebase.sv
// iob_clint_timebase: prescaler and 64-bit mtime with bus half-writes taking priority over the increment
module iob_clint_timebase import iob_clint_pkg::*; #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    logic [15:0] pre;
    logic        tick;

    assign tick = (CLK_DIV == 1) || (pre == 16'(CLK_DIV - 1));

    // Free-running prescaler; a half-write replaces that half and suppresses the tick for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre   <= '0;
            mtime <= '0;
        end else begin
            pre <= tick ? '0 : pre + 16'd1;
            if (wr_lo) mtime[31:0] <= strb_merge(mtime[31:0], wdata, wstrb);
            else if (wr_hi) mtime[63:32] <= strb_merge(mtime[63:32], wdata, wstrb);
            else if (tick) mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/iob_clint.sv
// iob_clint: RISC-V CLINT (msip, mtimecmp, mtime) as a native iob peripheral slave
module iob_clint import iob_clint_pkg::*; #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1,
    parameter int CLK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CORES-1:0]  timerInterrupt,
    output logic [N_CORES-1:0]  softwareInterrupt
);

    logic [15:0]        a;
    logic               acc, wr;
    logic               msip_hit, cmp_hit, lo_hit, hi_hit;
    logic [2:0]         h_m, h_c;
    logic [63:0]        mtime;
    logic [63:0]        cmp [N_CORES];
    logic [N_CORES-1:0] msip;
    logic [31:0]        rd;

    assign a        = address[15:0];
    assign acc      = valid & ~ready;
    assign wr       = acc & |wstrb;
    assign msip_hit = a[15:5] == MSIP_BASE[15:5];
    assign cmp_hit  = a[15:6] == MTIMECMP_BASE[15:6];
    assign lo_hit   = a[15:2] == MTIME_LO[15:2];
    assign hi_hit   = a[15:2] == MTIME_HI[15:2];
    assign h_m      = a[4:2];
    assign h_c      = a[5:3];
    assign softwareInterrupt = msip;

    iob_clint_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (wr & lo_hit),
        .wr_hi (wr & hi_hit),
        .wdata (wdata[31:0]),
        .wstrb (wstrb[3:0]),
        .mtime (mtime)
    );

    // Read mux; harts beyond N_CORES and unmapped holes fall through to zero
    always_comb begin
        rd = lo_hit ? mtime[31:0] : hi_hit ? mtime[63:32] : '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (msip_hit && h_m == 3'(i)) rd = {31'b0, msip[i]};
            if (cmp_hit && h_c == 3'(i)) rd = a[2] ? cmp[i][63:32] : cmp[i][31:0];
        end
    end

    // Handshake, register writes and registered timer compares
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready          <= 1'b0;
            rdata          <= '0;
            msip           <= '0;
            timerInterrupt <= '0;
            for (int i = 0; i < N_CORES; i++) cmp[i] <= MTIMECMP_RST;
        end else begin
            ready <= acc;
            rdata <= acc ? DATA_W'(rd) : '0;
            for (int i = 0; i < N_CORES; i++) begin
                if (wr && msip_hit && h_m == 3'(i) && wstrb[0]) msip[i] <= wdata[0];
                if (wr && cmp_hit && h_c == 3'(i) && a[2]) cmp[i][63:32] <= strb_merge(cmp[i][63:32], wdata[31:0], wstrb[3:0]);
                if (wr && cmp_hit && h_c == 3'(i) && !a[2]) cmp[i][31:0] <= strb_merge(cmp[i][31:0], wdata[31:0], wstrb[3:0]);
                timerInterrupt[i] <= mtime >= cmp[i];
            end
        end
    end

endmodule
